// File: rtl/mem_stage_banked.sv
// Banked MEM-stage data memory: four byte lanes, RV32 loads/stores, multi-cycle reads with stall.
// Define MEM_PARITY_EN to store an even-parity bit per lane and flag mismatches on load completion.
module mem_stage_banked #(
  parameter int DEPTH_WORDS = 8192,
  parameter int READ_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        m_MemRead,
  input  logic        m_MemWrite,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_mem_data,
  input  logic [31:0] wb_data,
  input  logic        wb_forward,
  output logic        stall_mem,
  output logic [31:0] read_data_MEMWB,
  output logic        rdata_valid,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        parity_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [2:0]  f3_reg;
  logic [1:0]  lane_reg;

  logic          req_act, is_acc, f3_legal, mis_c, oor_c, fault;
  logic          issue, load_nop, we;
  logic [AW-1:0] word_idx;
  logic [31:0]   store_data, wdata, rd_word, ext_data;
  logic [3:0]    be, rmask;

  // Reset masks the request so nothing issues, stalls or faults while rst is held.
  assign req_act  = req_valid & ~rst;
  assign is_acc   = req_act & (m_MemRead | m_MemWrite);
  assign f3_legal = (m_funct3 == 3'b000) || (m_funct3 == 3'b001) || (m_funct3 == 3'b010) ||
                    (m_funct3 == 3'b100) || (m_funct3 == 3'b101);
  assign mis_c    = is_acc & ((((m_funct3 == 3'b001) || (m_funct3 == 3'b101)) && m_alu_out[0]) ||
                              ((m_funct3 == 3'b010) && (m_alu_out[1:0] != 2'b00)));
  assign oor_c    = is_acc & ((m_alu_out >> (AW + 2)) != 32'd0);
  assign fault    = mis_c | oor_c;
  assign word_idx = m_alu_out[AW+1:2];

  assign issue    = (state_reg == S_IDLE) & req_act & m_MemRead & ~fault & f3_legal;
  assign load_nop = (state_reg == S_IDLE) & req_act & m_MemRead & (fault | ~f3_legal);

  assign store_data = wb_forward ? wb_data : m_mem_data;
  assign we         = req_act & m_MemWrite & ~fault;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    rmask = 4'b0000;
    case (m_funct3)
      3'b000: begin
        be    = 4'b0001 << m_alu_out[1:0];
        wdata = {4{store_data[7:0]}};
        rmask = 4'b0001 << m_alu_out[1:0];
      end
      3'b100: rmask = 4'b0001 << m_alu_out[1:0];
      3'b001: begin
        be    = m_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
        rmask = m_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      3'b101: rmask = m_alu_out[1] ? 4'b1100 : 4'b0011;
      3'b010: begin
        be    = 4'b1111;
        rmask = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef MEM_PARITY_EN
  logic [3:0] par_bad;
  logic [3:0] rmask_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [LANE_W-1:0] mem [DEPTH_WORDS];
      logic [LANE_W-1:0] rd_reg;
      logic [LANE_W-1:0] wr_lane;
`ifdef MEM_PARITY_EN
      assign wr_lane     = {^wdata[8*gi +: 8], wdata[8*gi +: 8]};
      assign par_bad[gi] = ^rd_reg;
`else
      assign wr_lane = wdata[8*gi +: 8];
`endif
      always_ff @(posedge clk) begin
        if (we && be[gi])
          mem[word_idx] <= wr_lane;
        if (issue)
          rd_reg <= mem[word_idx];
      end
      assign rd_word[8*gi +: 8] = rd_reg[7:0];
    end
  endgenerate

  // Read lanes only change on issue, so this stays valid through WAIT into DONE.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = rd_word[8*lane_reg +: 8];
    half_sel = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_reg)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      3'b010:  ext_data = rd_word;
      default: ext_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
      f3_reg    <= 3'd0;
      lane_reg  <= 2'd0;
`ifdef MEM_PARITY_EN
      rmask_reg <= 4'd0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (issue) begin
            cnt_reg   <= 3'(READ_LAT - 1);
            f3_reg    <= m_funct3;
            lane_reg  <= m_alu_out[1:0];
`ifdef MEM_PARITY_EN
            rmask_reg <= rmask;
`endif
            state_reg <= (READ_LAT == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1)
            state_reg <= S_DONE;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign stall_mem       = issue | (state_reg == S_WAIT);
  assign rdata_valid     = (state_reg == S_DONE) | load_nop;
  assign read_data_MEMWB = (state_reg == S_DONE) ? ext_data : 32'd0;
  assign misaligned      = mis_c;
  assign out_of_range    = oor_c;
`ifdef MEM_PARITY_EN
  assign parity_err      = (state_reg == S_DONE) & |(par_bad & rmask_reg);
`else
  assign parity_err      = 1'b0;
`endif

endmodule

// File: doc/mem_stage_banked.md
Name: mem_stage_banked

Overview:
- Parametrised successor to the single-cycle MEM-stage data memory.
- Four byte-lane banks of configurable depth; RV32 LB/LH/LW/LBU/LHU/SB/SH/SW.
- Configurable multi-cycle read latency with a real stall handshake to the pipeline.
- Misaligned and out-of-range access detection.
- Sits between the EX/MEM and MEM/WB buffers, driving stall_mem to the hazard unit.

Parameters:
- DEPTH_WORDS, 8192, words per bank set; power of two; byte address space = 4*DEPTH_WORDS.
- READ_LAT, 2, cycles from load issue to data valid; legal range 1..4.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  EX/MEM holds a valid memory instruction
- m_MemRead  input  1  load
- m_MemWrite  input  1  store; never asserted together with m_MemRead
- m_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- m_alu_out  input  32  byte address
- m_mem_data  input  32  store data from EX/MEM
- wb_data  input  32  forwarded store data from WB
- wb_forward  input  1  1 selects wb_data as store data
- stall_mem  output  1  freeze upstream stages and EX/MEM
- read_data_MEMWB  output  32  extended load result
- rdata_valid  output  1  read_data_MEMWB valid this cycle
- misaligned  output  1  H/HU with addr[0]=1, or W with addr[1:0]!=0
- out_of_range  output  1  addr >= 4*DEPTH_WORDS
- parity_err  output  1  see Optional Feature

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All outputs 0.
  - Latency counter 0.
  - Memory contents not reset.
- Reset mid-load: abort, stall_mem drops immediately (async), no write side effects.
- Word index = addr[2+log2(DEPTH_WORDS)-1:2]; lane = addr[1:0].
- Faults:
  - A fault is misaligned or out_of_range.
  - misaligned and out_of_range are combinational from the current request, qualified by req_valid and (m_MemRead | m_MemWrite).
  - Faulting access: no bank write, no stall, rdata_valid=1 for loads with data 0.
- Stores:
  - Single cycle, never stall.
  - Write occurs on the clock edge when req_valid & m_MemWrite & no fault.
  - SB writes the addressed lane from bits [7:0].
  - SH writes lanes {1,0} or {3,2} from [15:0].
  - SW writes all lanes.
  - Store data = wb_forward ? wb_data : m_mem_data.
- Loads, FSM:
  - IDLE:
    - Non-faulting load present: stall_mem=1 combinationally, issue read, load counter with READ_LAT-1.
    - If READ_LAT=1 go to DONE, else go to WAIT.
  - WAIT: stall_mem=1; decrement counter; at 0 go to DONE.
  - DONE:
    - stall_mem=0, rdata_valid=1, read_data_MEMWB = registered extended result.
    - Always go to IDLE (pipeline advances at this edge).
- Load latency and data rules:
  - A load issued in cycle T has data valid in cycle T+READ_LAT.
  - stall_mem is high for exactly READ_LAT cycles.
  - Upstream must hold the request stable while stall_mem=1; the address is captured at issue.
- Extension:
  - LB/LH sign-extend from the top byte read.
  - LBU/LHU zero-extend.
  - LW returns {lane3, lane2, lane1, lane0}.
- Back-to-back:
  - A load following a store to the same address reads the new data (store committed before the next issue).
  - A load directly after a load re-enters IDLE first; no overlap.
- Illegal m_funct3 is treated as a no-op: no write, no stall, rdata_valid=1 with data 0 for loads.
- req_valid=0: no access, outputs 0 except held FSM state.

Optional Feature:
- Macro MEM_PARITY_EN.
- Enabled:
  - Each lane stores an even-parity bit written with the data.
  - On load completion (DONE), parity_err=1 for one cycle if any read lane's parity mismatches; data is still returned.
- Disabled: no parity storage; parity_err tied 0.

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100, READ_LAT=2 -> stall_mem high 2 cycles, then read_data_MEMWB=0xDEADBEEF, rdata_valid=1.
- SB 0x80 @0x103, then LB / LBU @0x103 -> 0xFFFFFF80 / 0x00000080; other lanes of word 0x100 unchanged.
- SH @0x101 and LW @0x102 -> misaligned=1, no write, no stall; a later LW @0x100 shows prior contents.
- LW @4*DEPTH_WORDS -> out_of_range=1, data 0, stall_mem=0.
- SW with wb_forward=1, wb_data=0x12345678, m_mem_data=0 -> subsequent LW returns 0x12345678.
- Assert rst during WAIT -> stall_mem=0 same cycle; FSM back in IDLE; next load completes normally after READ_LAT.
